// File: rtl/tile_mem_arbiter_if.sv
// tile_mem_arbiter_if
//   Bundles the three buses around the tile BRAM arbiter.
//   AXI indirect port : mem_valid_axi, mem_addr_axi, mem_wdata_axi,
//                       mem_wstrb_axi -> mem_rdata_axi
//   Core native port  : mem_valid_core, mem_addr_core, mem_wdata_core,
//                       mem_wstrb_core -> mem_ready_core, mem_rdata_core
//   BRAM port         : bram_en, bram_we, bram_addr, bram_din <- bram_dout
//   Modport slave is the arbiter side; modport master is everything around it
//   (AXI control stage, core, BRAM).
interface tile_mem_arbiter_if #(
  parameter int BW     = 32,
  parameter int ADDR_W = 12
);
  localparam int BWB = BW / 8;

  logic              mem_valid_axi;
  logic [31:0]       mem_addr_axi;
  logic [BW-1:0]     mem_wdata_axi;
  logic              mem_wstrb_axi;
  logic [BW-1:0]     mem_rdata_axi;

  logic              mem_valid_core;
  logic [31:0]       mem_addr_core;
  logic [BW-1:0]     mem_wdata_core;
  logic [BWB-1:0]    mem_wstrb_core;
  logic              mem_ready_core;
  logic [BW-1:0]     mem_rdata_core;

  logic              bram_en;
  logic [BWB-1:0]    bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [BW-1:0]     bram_din;
  logic [BW-1:0]     bram_dout;

  modport slave (
    input  mem_valid_axi, mem_addr_axi, mem_wdata_axi, mem_wstrb_axi,
    output mem_rdata_axi,
    input  mem_valid_core, mem_addr_core, mem_wdata_core, mem_wstrb_core,
    output mem_ready_core, mem_rdata_core,
    output bram_en, bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  modport master (
    output mem_valid_axi, mem_addr_axi, mem_wdata_axi, mem_wstrb_axi,
    input  mem_rdata_axi,
    output mem_valid_core, mem_addr_core, mem_wdata_core, mem_wstrb_core,
    input  mem_ready_core, mem_rdata_core,
    input  bram_en, bram_we, bram_addr, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter
//   Shares the tile's single-port local BRAM between the AXI-lite indirect
//   memory port and the RISC-V core's native valid/ready port. The AXI side
//   cannot be back-pressured, so it always wins; the core is stalled instead.
//   Ports:
//     clk_control          single clock for the whole block
//     clk_control_rst_high asynchronous active-high reset
//     core_enable          rvControl[0]; gates acceptance of core requests
//     bus                  AXI / core / BRAM signals (tile_mem_arbiter_if.slave)
//     core_stall_count     saturating count of core cycles lost to AXI
//     core_oob_count       saturating count of out-of-range core accesses
//
//   Core FSM
//   state | meaning
//   IDLE  | waiting for a core request; AXI traffic has priority
//   ISSUE | core access is in the BRAM (registered port cycle)
//   WAIT  | BRAM read data valid; capture it (or 0) for the core
//   RESP  | mem_ready_core high for this one cycle
module tile_mem_arbiter #(
  parameter int BW     = 32,
  parameter int BWB    = BW / 8,
  parameter int ADDR_W = 12
) (
  input  logic                 clk_control,
  input  logic                 clk_control_rst_high,
  input  logic                 core_enable,
  tile_mem_arbiter_if.slave    bus,
  output logic [BW-1:0]        core_stall_count,
  output logic [BW-1:0]        core_oob_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic core_req;
  logic core_oob;
  logic core_accept;
  logic core_issue;
  logic stall_inc;
  logic oob_inc;

  // Set when the accepted core access is an in-range read; selects
  // bram_dout versus zero in WAIT.
  logic core_rd;

  // Two-stage tag following an AXI read through the BRAM pipeline so its
  // data is captured into mem_rdata_axi and never confused with core data.
  logic axi_rd_tag1;
  logic axi_rd_tag2;

  // Byte-offset bits and AXI address bits above the BRAM are ignored
  // (AXI wraps by truncation).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr_axi[31:ADDR_W+2], bus.mem_addr_axi[1:0],
                              bus.mem_addr_core[1:0]};

  assign core_req = bus.mem_valid_core && core_enable;
  assign core_oob = |bus.mem_addr_core[31:ADDR_W+2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    core_accept = 1'b0;
    core_issue  = 1'b0;
    stall_inc   = 1'b0;
    oob_inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req) begin
          if (bus.mem_valid_axi) begin
            stall_inc = 1'b1;
          end else begin
            core_accept = 1'b1;
            if (core_oob) begin
              // No BRAM access; skip ISSUE so the WAIT/RESP shape is shared.
              oob_inc    = 1'b1;
              next_state = WAIT;
            end else begin
              core_issue = 1'b1;
              next_state = ISSUE;
            end
          end
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.mem_ready_core = (state == RESP);

  // ---------------------------------------------------- BRAM port registers
  // Address and write data hold when idle; only enable and write enables drop.
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else if (bus.mem_valid_axi) begin
      bus.bram_en   <= 1'b1;
      bus.bram_we   <= {BWB{bus.mem_wstrb_axi}};
      bus.bram_addr <= bus.mem_addr_axi[ADDR_W+1:2];
      bus.bram_din  <= bus.mem_wdata_axi;
    end else if (core_issue) begin
      bus.bram_en   <= 1'b1;
      bus.bram_we   <= bus.mem_wstrb_core;
      bus.bram_addr <= bus.mem_addr_core[ADDR_W+1:2];
      bus.bram_din  <= bus.mem_wdata_core;
    end else begin
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
    end
  end

  // ------------------------------------------------------- AXI read return
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      axi_rd_tag1       <= 1'b0;
      axi_rd_tag2       <= 1'b0;
      bus.mem_rdata_axi <= '0;
    end else begin
      axi_rd_tag1 <= bus.mem_valid_axi && !bus.mem_wstrb_axi;
      axi_rd_tag2 <= axi_rd_tag1;
      if (axi_rd_tag2) begin
        bus.mem_rdata_axi <= bus.bram_dout;
      end
    end
  end

  // ------------------------------------------------------ core read return
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      core_rd            <= 1'b0;
      bus.mem_rdata_core <= '0;
    end else begin
      if (core_accept) begin
        core_rd <= !core_oob && (bus.mem_wstrb_core == '0);
      end
      if (state == WAIT) begin
        bus.mem_rdata_core <= core_rd ? bus.bram_dout : '0;
      end
    end
  end

  // ------------------------------------------------------------- counters
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      core_stall_count <= '0;
      core_oob_count   <= '0;
    end else begin
      if (stall_inc && (core_stall_count != '1)) begin
        core_stall_count <= core_stall_count + 1'b1;
      end
      if (oob_inc && (core_oob_count != '1)) begin
        core_oob_count <= core_oob_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tile_mem_arbiter.sv
module tb_tile_mem_arbiter;
  localparam int BW     = 32;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_enable = 1'b0;
  logic [BW-1:0] core_stall_count;
  logic [BW-1:0] core_oob_count;

  tile_mem_arbiter_if #(.BW(BW), .ADDR_W(ADDR_W)) bus ();

  tile_mem_arbiter #(.BW(BW), .ADDR_W(ADDR_W)) dut (
    .clk_control          (clk),
    .clk_control_rst_high (rst),
    .core_enable          (core_enable),
    .bus                  (bus),
    .core_stall_count     (core_stall_count),
    .core_oob_count       (core_oob_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: read-first, 1-cycle read latency, byte write enables.
  logic [31:0] bmem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) bmem[bus.bram_addr][8*b +: 8] <= bus.bram_din[8*b +: 8];
      bus.bram_dout <= bmem[bus.bram_addr];
    end
  end

  // Reference memory contents, updated in stimulus order.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

  typedef struct { int due; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [3:0] we; logic [11:0] addr; logic [31:0] din; } bram_exp_t;
  exp_t      axi_q [$];
  exp_t      core_q [$];
  bram_exp_t bram_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int ready_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [11:0] w, input logic [3:0] strb, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  // Drive one AXI access for the coming edge and record its expectations.
  task automatic axi_issue(input bit we, input logic [31:0] addr, input logic [31:0] data);
    bram_exp_t be;
    exp_t e;
    bus.mem_valid_axi = 1'b1;
    bus.mem_wstrb_axi = we;
    bus.mem_addr_axi  = addr;
    bus.mem_wdata_axi = data;
    be.due = cyc + 1; be.we = {4{we}}; be.addr = addr[13:2]; be.din = data;
    bram_q.push_back(be);
    if (we) ref_write(addr[13:2], 4'hF, data);
    else begin
      e.due = cyc + 3; e.data = ref_mem[addr[13:2]];
      axi_q.push_back(e);
    end
  endtask

  // Core request to be accepted at the coming edge (no AXI in that cycle).
  task automatic core_push(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] data);
    bram_exp_t be;
    exp_t e;
    logic oob;
    oob = (addr[31:14] != 0);
    bus.mem_valid_core = 1'b1;
    bus.mem_wstrb_core = strb;
    bus.mem_addr_core  = addr;
    bus.mem_wdata_core = data;
    if (oob) begin
      e.due = cyc + 2; e.data = 32'h0;
    end else begin
      be.due = cyc + 1; be.we = strb; be.addr = addr[13:2]; be.din = data;
      bram_q.push_back(be);
      e.due = cyc + 3;
      e.data = (strb == 4'h0) ? ref_mem[addr[13:2]] : 32'h0;
      if (strb != 4'h0) ref_write(addr[13:2], strb, data);
    end
    core_q.push_back(e);
  endtask

  task automatic core_wait();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_ready_core) seen = 1'b1;
    end
    if (!seen) chk("core_timeout", bus.mem_ready_core, 1'b1);
    step();
    bus.mem_valid_core = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  exp_t      me;
  bram_exp_t mb;
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_q.size() > 0 && axi_q[0].due == cyc) begin
        me = axi_q.pop_front();
        chk("axi_rdata", bus.mem_rdata_axi, me.data);
      end
      if (bus.mem_ready_core) begin
        ready_cnt++;
        if (core_q.size() == 0) chk("core_ready_unexpected", bus.mem_ready_core, 1'b0);
        else begin
          me = core_q.pop_front();
          chk("core_rdata", bus.mem_rdata_core, me.data);
          chk("core_ready_cycle", cyc, me.due);
        end
      end else if (core_q.size() > 0 && core_q[0].due < cyc) begin
        void'(core_q.pop_front());
        chk("core_ready_missing", bus.mem_ready_core, 1'b1);
      end
      if (bus.bram_en) begin
        if (bram_q.size() == 0 || bram_q[0].due != cyc) chk("bram_en_unexpected", bus.bram_en, 1'b0);
        else begin
          mb = bram_q.pop_front();
          chk("bram_addr", bus.bram_addr, mb.addr);
          chk("bram_we", bus.bram_we, mb.we);
          if (mb.we != 4'h0) chk("bram_din", bus.bram_din, mb.din);
        end
      end else if (bram_q.size() > 0 && bram_q[0].due <= cyc) begin
        void'(bram_q.pop_front());
        chk("bram_en_missing", bus.bram_en, 1'b1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.mem_ready_core, 1'b0);
    chk({tag, "_rdata_core"}, bus.mem_rdata_core, 32'h0);
    chk({tag, "_rdata_axi"}, bus.mem_rdata_axi, 32'h0);
    chk({tag, "_bram_en"}, bus.bram_en, 1'b0);
    chk({tag, "_bram_we"}, bus.bram_we, 4'h0);
    chk({tag, "_bram_addr"}, bus.bram_addr, 12'h0);
    chk({tag, "_bram_din"}, bus.bram_din, 32'h0);
    chk({tag, "_stall_cnt"}, core_stall_count, 32'h0);
    chk({tag, "_oob_cnt"}, core_oob_count, 32'h0);
  endtask

  int r0;

  initial begin
    bus.mem_valid_axi = 1'b0; bus.mem_addr_axi = '0; bus.mem_wdata_axi = '0; bus.mem_wstrb_axi = 1'b0;
    bus.mem_valid_core = 1'b0; bus.mem_addr_core = '0; bus.mem_wdata_core = '0; bus.mem_wstrb_core = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    core_enable = 1'b1;
    step();

    // Test 1 plus preloads: AXI writes then AXI read back of 0x10.
    axi_issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF); step();
    axi_issue(1'b1, 32'h0000_0020, 32'h1234_5678); step();
    axi_issue(1'b1, 32'h0000_0024, 32'hCAFE_0001); step();
    axi_issue(1'b1, 32'h0000_0040, 32'hFFFF_FFFF); step();
    axi_issue(1'b0, 32'h0000_0010, 32'h0);         step();
    // Address above range wraps by truncation onto word 8 (0x20).
    axi_issue(1'b0, 32'h0001_0020, 32'h0);         step();
    bus.mem_valid_axi = 1'b0;
    repeat (4) step();

    // Test 2: core read with no AXI traffic.
    core_push(4'h0, 32'h0000_0020, 32'h0);
    core_wait();
    step();

    // core_enable low: request is not accepted.
    core_enable = 1'b0;
    bus.mem_valid_core = 1'b1; bus.mem_wstrb_core = 4'h0; bus.mem_addr_core = 32'h24;
    r0 = ready_cnt;
    repeat (5) step();
    chk("enable_low_no_ready", ready_cnt - r0, 0);
    core_enable = 1'b1;
    core_push(4'h0, 32'h0000_0024, 32'h0);
    step();
    core_enable = 1'b0;   // falls mid-transaction; access still completes
    core_wait();
    core_enable = 1'b1;
    step();

    // Test 3: core held off by 5 cycles of AXI traffic.
    bus.mem_valid_core = 1'b1; bus.mem_wstrb_core = 4'h0; bus.mem_addr_core = 32'h20;
    for (int i = 0; i < 5; i++) begin
      axi_issue(1'b0, (i % 2 == 0) ? 32'h10 : 32'h24, 32'h0);
      step();
    end
    bus.mem_valid_axi = 1'b0;
    core_push(4'h0, 32'h0000_0020, 32'h0);
    step();
    axi_issue(1'b0, 32'h0000_0010, 32'h0);   // AXI during in-flight core read
    step();
    bus.mem_valid_axi = 1'b0;
    core_wait();
    chk("stall_count", core_stall_count, 32'd5);
    step();

    // Test 4: core byte write over 0xFFFFFFFF, then AXI read back.
    core_push(4'b0010, 32'h0000_0040, 32'h0000_AB00);
    core_wait();
    axi_issue(1'b0, 32'h0000_0040, 32'h0); step();
    bus.mem_valid_axi = 1'b0;
    repeat (4) step();
    chk("ref_byte_merge", ref_mem[16], 32'hFFFF_ABFF);

    // Test 5: out-of-range core read.
    core_push(4'h0, 32'h0010_0000, 32'h0);
    core_wait();
    chk("oob_count", core_oob_count, 32'd1);
    step();

    // Test 6: reset asserted while the FSM is in WAIT.
    core_push(4'h0, 32'h0000_0024, 32'h0);
    step();          // accepted -> ISSUE
    step();          // ISSUE -> WAIT
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.mem_valid_core = 1'b0;
    core_q.delete(); bram_q.delete(); axi_q.delete();
    repeat (2) step();
    rst = 1'b0;
    r0 = ready_cnt;
    repeat (6) step();
    chk("no_ready_after_rst", ready_cnt - r0, 0);
    core_push(4'h0, 32'h0000_0020, 32'h0);
    core_wait();
    repeat (4) step();

    chk("axi_q_drained", axi_q.size(), 0);
    chk("core_q_drained", core_q.size(), 0);
    chk("bram_q_drained", bram_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares the tile's single-port local BRAM between two requesters:
  - the AXI-lite indirect memory port, driven by the tile control logic on the clk_control domain;
  - the RISC-V core's native memory port (valid/ready style).
- The AXI side has no backpressure, so it always wins arbitration; the core is stalled instead.
- Sits directly downstream of the tile AXI control stage and consumes its mem_valid_axi, mem_addr_axi, mem_wdata_axi and mem_wstrb_axi outputs.
- Returns mem_rdata_axi and also drives the BRAM pins.

Parameters:
- BW, 32, data width in bits.
- BWB, BW/8, byte-lane count.
- ADDR_W, 12, BRAM word-address width; depth is 2^ADDR_W words.

Ports:
- clk_control  in  1  single clock for the whole block.
- clk_control_rst_high  in  1  reset, asynchronous, active-high.
- mem_valid_axi  in  1  AXI access strobe; each high cycle is one independent access.
- mem_addr_axi  in  32  AXI byte address.
- mem_wdata_axi  in  BW  AXI write data.
- mem_wstrb_axi  in  1  AXI write enable (all lanes); 0 = read.
- mem_rdata_axi  out  BW  AXI read data; holds the last AXI read result.
- core_enable  in  1  rvControl[0]; core requests are ignored while low.
- mem_valid_core  in  1  core request; held high until the ready cycle.
- mem_addr_core  in  32  core byte address.
- mem_wdata_core  in  BW  core write data.
- mem_wstrb_core  in  BWB  core byte strobes; 0 = read.
- mem_ready_core  out  1  one-cycle completion pulse.
- mem_rdata_core  out  BW  core read data; valid when mem_ready_core is high.
- bram_en  out  1  BRAM enable.
- bram_we  out  BWB  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM word address.
- bram_din  out  BW  BRAM write data.
- bram_dout  in  BW  BRAM read data; synchronous, 1-cycle latency.
- core_stall_count  out  BW  saturating count of cycles the core was blocked by AXI.
- core_oob_count  out  BW  saturating count of out-of-range core accesses.

Behaviour:

Reset (async assert, sync deassert):
- All outputs go to 0.
- FSM goes to IDLE.
- Any pending core access is dropped; no ready pulse is ever issued for it.

BRAM port registers:
- All BRAM port outputs are registered.
- The request sampled at edge e0 drives the BRAM during cycle c1.
- bram_dout is valid in c2 and is captured at edge e2.

AXI path:
- When mem_valid_axi is high at an edge, the block issues:
  - bram_en=1
  - bram_we={BWB{mem_wstrb_axi}}
  - bram_addr=mem_addr_axi[ADDR_W+1:2]
  - bram_din=mem_wdata_axi
- AXI reads load mem_rdata_axi at e2, so data is visible from c3. The value holds until the next AXI read.
- AXI writes do not change mem_rdata_axi.
- Back-to-back AXI accesses issue every cycle.
- AXI addresses above range wrap by truncation.

Core FSM (states IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - Accepts only if mem_valid_core && core_enable && !mem_valid_axi.
  - In-range access: issue to BRAM, go to ISSUE.
  - Out-of-range access (mem_addr_core[31:ADDR_W+2]!=0): no BRAM access, core_oob_count++, go to WAIT.
  - If mem_valid_core && core_enable && mem_valid_axi: core_stall_count++ and stay in IDLE.
- ISSUE -> WAIT unconditionally.
- WAIT:
  - Capture bram_dout into mem_rdata_core (0 for out-of-range or for writes).
  - Go to RESP.
- RESP:
  - mem_ready_core=1 for exactly this cycle.
  - Go to IDLE.
  - mem_valid_core is ignored in ISSUE, WAIT and RESP.
- Minimum core latency is acceptance edge + 3 cycles to ready.
- A core access already in flight is never disturbed by a new AXI access: the BRAM pipeline is pipelined, and the tag register distinguishes AXI from core read data.

Core write:
- bram_we=mem_wstrb_core, bram_din=mem_wdata_core.
- mem_ready_core fires in RESP with mem_rdata_core=0.

core_enable falling mid-transaction:
- The in-flight access completes normally.
- No new access is accepted.

Counters:
- Both counters saturate at 2^BW-1.
- They are cleared only by reset.

Idle BRAM port:
- When nothing is issued: bram_en=0, bram_we=0.
- bram_addr and bram_din hold their previous values.

Test Plan:
1. AXI write 0xDEADBEEF at byte address 0x10, then AXI read at 0x10:
   - bram_addr=4 on both issues.
   - mem_rdata_axi=0xDEADBEEF from 3 cycles after the read strobe.
2. Core read at 0x20 (preloaded 0x12345678), no AXI traffic:
   - mem_ready_core pulses exactly once, 3 cycles after acceptance.
   - mem_rdata_core=0x12345678.
3. mem_valid_core high while mem_valid_axi is held high for 5 cycles:
   - Core accepted on the first cycle AXI is low.
   - core_stall_count=5.
   - The AXI accesses are unaffected.
4. Core byte write wstrb=4'b0010 with data 0x0000AB00 over 0xFFFFFFFF:
   - A subsequent AXI read returns 0xFFFFABFF.
5. Core read at 0x0010_0000 with ADDR_W=12:
   - No bram_en.
   - mem_ready_core pulses with mem_rdata_core=0.
   - core_oob_count=1.
6. Assert reset during WAIT:
   - All outputs go to 0 immediately.
   - No ready pulse after deassertion.
   - The next core request completes normally.
